// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants and types for the video/system SRAM arbiter.
//   - Slot numbering of the 16-cycle frame (video window first, host second).
//   - Access FSM state encoding and requester identifiers.
package vmem_pkg;

    localparam logic [3:0] VID_FIRST  = 4'd0;
    localparam logic [3:0] HOST_FIRST = 4'd8;
    localparam int         FRAME_LEN  = 16;

    // Gray-coded so the combinational strobe decodes (SRAM_WE_N, acks) never
    // pass through a neighbouring state's code on a transition.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC1 = 2'b01,
        ACC2 = 2'b11,
        ACK  = 2'b10
    } acc_state_t;

    typedef enum logic {
        CPU = 1'b0,
        AUX = 1'b1
    } req_id_t;

    // Slot whose closing edge opens the window starting at 'slot'.
    function automatic logic [3:0] slot_before(input logic [3:0] slot);
        return slot - 4'd1;
    endfunction

endpackage

// File: rtl/vmem_slot_timer.sv
// vmem_slot_timer: frame slot counter and timing decode.
//   clk24, reset_n : clock and asynchronous active-low reset
//   retrace        : video outside visible Y area (sampled once per frame)
//   s              : current slot 0..15
//   rt_q           : retrace state latched for the current frame
//   ce12           : 12 MHz enable (s[0])
//   video_slice    : current slot belongs to video
//   pipe_ab        : plane-pair select (s[2])
//   host_start     : next edge opens the host window at slot 8
//   rt_start       : next edge opens a retrace host window at slot 0
//   frame_end      : current slot is the last of the frame
module vmem_slot_timer
    import vmem_pkg::*;
(
    input  logic       clk24,
    input  logic       reset_n,
    input  logic       retrace,
    output logic [3:0] s,
    output logic       rt_q,
    output logic       ce12,
    output logic       video_slice,
    output logic       pipe_ab,
    output logic       host_start,
    output logic       rt_start,
    output logic       frame_end
);

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            s    <= 4'd0;
            rt_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop here samples the pre-edge value of s.
            s <= s + 4'd1;
            if (frame_end) begin
                rt_q <= retrace;
            end
        end
    end

    assign frame_end   = (s == 4'(FRAME_LEN - 1));
    assign ce12        = s[0];
    assign pipe_ab     = s[2];
    assign video_slice = ~s[3] & ~rt_q;

    assign host_start  = (s == slot_before(HOST_FIRST));
    // The retrace window opens on the same edge that latches rt_q, so it
    // must look at the live retrace input rather than rt_q.
    assign rt_start    = (s == slot_before(VID_FIRST)) & retrace;

endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: time-slot scheduler and arbiter for the shared 8-bit SRAM.
//   clk24, reset_n          : clock and asynchronous active-low reset
//   retrace                 : video outside visible area
//   vid_addr / vid_data     : framebuffer fetch address / fetched byte
//   ce12, video_slice, pipe_ab : timing for the video path
//   cpu_* / aux_*           : host requesters (req/we/addr/wdata in, ack/rdata out)
//   SRAM_ADDR, SRAM_DQ_i, SRAM_DQ_o, SRAM_DQ_oe, SRAM_WE_N : SRAM pins
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int AUX_STARVE = 3
) (
    input  logic              clk24,
    input  logic              reset_n,
    input  logic              retrace,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_data,
    output logic              ce12,
    output logic              video_slice,
    output logic              pipe_ab,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_ack,
    output logic [7:0]        aux_rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic [7:0]        SRAM_DQ_i,
    output logic [7:0]        SRAM_DQ_o,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_WE_N
);

    localparam int STARVE_W = (AUX_STARVE < 1) ? 1 : $clog2(AUX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(AUX_STARVE);

    logic [3:0] s;
    logic       rt_q;
    logic       host_start;
    logic       rt_start;
    logic       frame_end;

    vmem_slot_timer u_timer (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .retrace     (retrace),
        .s           (s),
        .rt_q        (rt_q),
        .ce12        (ce12),
        .video_slice (video_slice),
        .pipe_ab     (pipe_ab),
        .host_start  (host_start),
        .rt_start    (rt_start),
        .frame_end   (frame_end)
    );

    acc_state_t          state_q, state_d;
    req_id_t             owner_q;
    logic                acc_we_q;
    logic [STARVE_W-1:0] starve_q;

    logic                win_start;
    logic                grant;
    logic                aux_pick;
    logic [ADDR_W-1:0]   pick_addr;
    logic [7:0]          pick_wdata;
    logic                pick_we;
    logic                vid_load;
    logic                vid_cap;

    assign win_start = host_start | rt_start;

    // Aux only overrides the CPU once it has lost AUX_STARVE windows in a row.
    assign aux_pick   = aux_req & (~cpu_req | (starve_q == STARVE_MAX));
    assign pick_addr  = aux_pick ? aux_addr  : cpu_addr;
    assign pick_wdata = aux_pick ? aux_wdata : cpu_wdata;
    assign pick_we    = aux_pick ? aux_we    : cpu_we;

    // Video fetch strobes. Slot 0's address is loaded on the frame's closing
    // edge, so it depends on whether the coming frame is a retrace frame.
    assign vid_load = frame_end ? ~retrace
                                : (~rt_q & ~s[3] & s[0] & (s != 4'd7));
    assign vid_cap  = ~rt_q & ~s[3] & s[0];

    always_comb begin
        // NOTE: defaults are assigned first so no branch can infer a latch.
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_start && (cpu_req || aux_req)) begin
                    grant   = 1'b1;
                    state_d = ACC1;
                end
            end
            ACC1:    state_d = ACC2;
            ACC2:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= CPU;
            acc_we_q  <= 1'b0;
            starve_q  <= '0;
            SRAM_ADDR <= '0;
            SRAM_DQ_o <= 8'h00;
            cpu_rdata <= 8'h00;
            aux_rdata <= 8'h00;
            vid_data  <= 8'h00;
        end else begin
            if (grant) begin
                owner_q   <= aux_pick ? AUX : CPU;
                acc_we_q  <= pick_we;
                SRAM_ADDR <= pick_addr;
                SRAM_DQ_o <= pick_wdata;
                if (aux_pick) begin
                    starve_q <= '0;
                end else if (aux_req && (starve_q != STARVE_MAX)) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else if (vid_load) begin
                SRAM_ADDR <= vid_addr;
            end

            if (vid_cap) begin
                vid_data <= SRAM_DQ_i;
            end

            if (state_q == ACC2 && !acc_we_q) begin
                if (owner_q == AUX) begin
                    aux_rdata <= SRAM_DQ_i;
                end else begin
                    cpu_rdata <= SRAM_DQ_i;
                end
            end
        end
    end

    // Pin strobes decode straight from the state register so an asynchronous
    // reset releases the bus in the same instant it is asserted.
    assign SRAM_WE_N  = ~((state_q == ACC2) & acc_we_q);
    assign SRAM_DQ_oe = (state_q != IDLE) & acc_we_q;
    assign cpu_ack    = (state_q == ACK) & (owner_q == CPU);
    assign aux_ack    = (state_q == ACK) & (owner_q == AUX);

endmodule
